// File: rtl/ir_sequencer.sv
// -----------------------------------------------------------------------------
// ir_sequencer
//
// Fetch/decode/execute control FSM for the 8-bit processor datapath. It steps
// through instruction fetch (via the address register and synchronous-read
// memory), decodes the opcode/src/dest fields of the instruction register and
// drives the bus mux selects and load strobes of every datapath step.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   - an illegal opcode (9..14) seen in S_DEC sets the sticky err
//               flag and parks the FSM in S_HALT.
//   undefined - an illegal opcode is treated as NOP and err is tied to 0.
//
// Parameters
//   word_size   width of the instruction input (8)
//   op_size     opcode field width, instruction[7:4] (4)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   instruction  in   instruction register output {opcode, src, dest}
//   zero         in   zero flag from the Z register (used only in S_DEC)
//   load_ir      out  instruction register load
//   load_add_r   out  address register load
//   load_pc      out  program counter load
//   inc_pc       out  program counter increment
//   load_reg     out  one-hot register file write enable, R0..R3
//   load_reg_y   out  ALU operand Y load
//   load_reg_z   out  zero flag register load
//   sel_bus1     out  Bus1 source: 0..3 = R0..R3, 4 = PC
//   sel_bus2     out  Bus2 source: 0 = ALU, 1 = Bus1, 2 = memory
//   alu_op       out  opcode passed through to the ALU
//   write        out  memory write strobe
//   halted       out  high while in S_HALT
//   err          out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module ir_sequencer #(
    parameter int word_size = 8,
    parameter int op_size   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic [3:0]           load_reg,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic [2:0]           sel_bus1,
    output logic [1:0]           sel_bus2,
    output logic [op_size-1:0]   alu_op,
    output logic                 write,
    output logic                 halted,
    output logic                 err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam logic [op_size-1:0] OP_NOP  = op_size'(0);
    localparam logic [op_size-1:0] OP_ADD  = op_size'(1);
    localparam logic [op_size-1:0] OP_SUB  = op_size'(2);
    localparam logic [op_size-1:0] OP_AND  = op_size'(3);
    localparam logic [op_size-1:0] OP_NOT  = op_size'(4);
    localparam logic [op_size-1:0] OP_RD   = op_size'(5);
    localparam logic [op_size-1:0] OP_WR   = op_size'(6);
    localparam logic [op_size-1:0] OP_BR   = op_size'(7);
    localparam logic [op_size-1:0] OP_BRZ  = op_size'(8);
    localparam logic [op_size-1:0] OP_HALT = op_size'(15);

    localparam logic [2:0] BUS1_PC   = 3'd4;
    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;

    state_t               state;
    logic [op_size-1:0]   opcode;
    logic [1:0]           src;
    logic [1:0]           dest;

    assign opcode = instruction[word_size-1 -: op_size];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // -------------------------------------------------------------------------
    // State register and sticky error flag
    // -------------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
`ifdef ILLEGAL_TRAP_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: state <= S_FET1;
                S_FET1: state <= S_FET2;
                S_FET2: state <= S_DEC;
                S_DEC: begin
                    case (opcode)
                        OP_NOP:                 state <= S_FET1;
                        OP_ADD, OP_SUB, OP_AND: state <= S_EX1;
                        OP_NOT:                 state <= S_FET1;
                        OP_RD:                  state <= S_RD1;
                        OP_WR:                  state <= S_WR1;
                        OP_BR:                  state <= S_BR1;
                        // Not-taken BRZ skips its address byte via inc_pc in S_DEC.
                        OP_BRZ:                 state <= zero ? S_BR1 : S_FET1;
                        OP_HALT:                state <= S_HALT;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            state <= S_HALT;
                            err_q <= 1'b1;
`else
                            state <= S_FET1;
`endif
                        end
                    endcase
                end
                S_EX1:  state <= S_FET1;
                S_RD1:  state <= S_RD2;
                S_RD2:  state <= S_FET1;
                S_WR1:  state <= S_WR2;
                S_WR2:  state <= S_FET1;
                S_BR1:  state <= S_BR2;
                S_BR2:  state <= S_FET1;
                // Only reset leaves S_HALT.
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Output decode
    // Outputs are a pure function of state/instruction/zero. They are also
    // gated with rst so every output (alu_op and halted included) is 0 for
    // the whole reset interval, and a write in S_WR2 is cut the instant rst
    // rises rather than waiting for the state register to settle.
    // -------------------------------------------------------------------------
    always_comb begin
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_reg   = 4'b0000;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus1   = 3'd0;
        sel_bus2   = BUS2_ALU;
        alu_op     = '0;
        write      = 1'b0;
        halted     = 1'b0;

        if (!rst) begin
            alu_op = opcode;
            case (state)
                S_FET1: begin
                    sel_bus1   = BUS1_PC;
                    sel_bus2   = BUS2_BUS1;
                    load_add_r = 1'b1;
                end
                S_FET2: begin
                    sel_bus2 = BUS2_MEM;
                    load_ir  = 1'b1;
                    inc_pc   = 1'b1;
                end
                S_DEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND: begin
                            sel_bus1   = {1'b0, src};
                            load_reg_y = 1'b1;
                        end
                        OP_NOT: begin
                            sel_bus1   = {1'b0, src};
                            sel_bus2   = BUS2_ALU;
                            load_reg   = reg_onehot(dest);
                            load_reg_z = 1'b1;
                        end
                        // Memory and branch ops first point the address
                        // register at the operand byte that follows.
                        OP_RD, OP_WR, OP_BR: begin
                            sel_bus1   = BUS1_PC;
                            sel_bus2   = BUS2_BUS1;
                            load_add_r = 1'b1;
                        end
                        OP_BRZ: begin
                            if (zero) begin
                                sel_bus1   = BUS1_PC;
                                sel_bus2   = BUS2_BUS1;
                                load_add_r = 1'b1;
                            end else begin
                                inc_pc = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_EX1: begin
                    sel_bus1   = {1'b0, dest};
                    sel_bus2   = BUS2_ALU;
                    load_reg   = reg_onehot(dest);
                    load_reg_z = 1'b1;
                end
                S_RD1, S_WR1: begin
                    // Operand byte holds the data address; consume it.
                    sel_bus2   = BUS2_MEM;
                    load_add_r = 1'b1;
                    inc_pc     = 1'b1;
                end
                S_RD2: begin
                    sel_bus2 = BUS2_MEM;
                    load_reg = reg_onehot(dest);
                end
                S_WR2: begin
                    sel_bus1 = {1'b0, src};
                    write    = 1'b1;
                end
                S_BR1: begin
                    sel_bus2   = BUS2_MEM;
                    load_add_r = 1'b1;
                end
                S_BR2: begin
                    sel_bus2 = BUS2_MEM;
                    load_pc  = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ir_sequencer
//
// Self-checking bench for ir_sequencer. Expected per-cycle output vectors are
// queued from the instruction-level behaviour table as each instruction is
// scheduled and compared against the DUT one cycle at a time.
// Vector layout: {load_ir, load_add_r, load_pc, inc_pc, load_reg[3:0],
//                 load_reg_y, load_reg_z, sel_bus1[2:0], sel_bus2[1:0],
//                 alu_op[3:0], write, halted, err}
// -----------------------------------------------------------------------------
module tb_ir_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;

    logic       load_ir, load_add_r, load_pc, inc_pc;
    logic [3:0] load_reg;
    logic       load_reg_y, load_reg_z;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic [3:0] alu_op;
    logic       write, halted, err;

    ir_sequencer #(.word_size(8), .op_size(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .load_ir(load_ir), .load_add_r(load_add_r), .load_pc(load_pc),
        .inc_pc(inc_pc), .load_reg(load_reg), .load_reg_y(load_reg_y),
        .load_reg_z(load_reg_z), .sel_bus1(sel_bus1), .sel_bus2(sel_bus2),
        .alu_op(alu_op), .write(write), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {load_ir, load_add_r, load_pc, inc_pc, load_reg, load_reg_y,
                  load_reg_z, sel_bus1, sel_bus2, alu_op, write, halted, err};

    typedef struct {
        logic        drive;
        logic [7:0]  ins;
        logic        z;
        logic [21:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    item_t it;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [21:0] v(input logic ir, input logic ar,
                                      input logic pc, input logic inc,
                                      input logic [3:0] lr, input logic ly,
                                      input logic lz, input logic [2:0] b1,
                                      input logic [1:0] b2, input logic [3:0] op,
                                      input logic wr, input logic h,
                                      input logic e);
        return {ir, ar, pc, inc, lr, ly, lz, b1, b2, op, wr, h, e};
    endfunction

    task automatic push(input logic drive, input logic [7:0] ins, input logic z,
                        input logic [21:0] exp, input string name);
        item_t x;
        x.drive = drive; x.ins = ins; x.z = z; x.exp = exp; x.name = name;
        sb.push_back(x);
    endtask

    // Expected cycles of one instruction, FET1 up to its last state.
    task automatic push_instr(input logic [7:0] ins, input logic z, input string tag);
        logic [3:0] op;
        logic [1:0] s, d;
        logic [3:0] oh;
        op = ins[7:4]; s = ins[3:2]; d = ins[1:0];
        oh = 4'b0001 << d;
        push(1'b1, ins, z, v(0,1,0,0,4'h0,0,0,3'd4,2'd1,op,0,0,0), {tag, "_fet1"});
        push(1'b0, ins, z, v(1,0,0,1,4'h0,0,0,3'd0,2'd2,op,0,0,0), {tag, "_fet2"});
        case (op)
            4'd1, 4'd2, 4'd3: begin
                push(1'b0, ins, z, v(0,0,0,0,4'h0,1,0,{1'b0,s},2'd0,op,0,0,0), {tag, "_dec"});
                push(1'b0, ins, z, v(0,0,0,0,oh,0,1,{1'b0,d},2'd0,op,0,0,0), {tag, "_ex1"});
            end
            4'd4:
                push(1'b0, ins, z, v(0,0,0,0,oh,0,1,{1'b0,s},2'd0,op,0,0,0), {tag, "_dec"});
            4'd5: begin
                push(1'b0, ins, z, v(0,1,0,0,4'h0,0,0,3'd4,2'd1,op,0,0,0), {tag, "_dec"});
                push(1'b0, ins, z, v(0,1,0,1,4'h0,0,0,3'd0,2'd2,op,0,0,0), {tag, "_rd1"});
                push(1'b0, ins, z, v(0,0,0,0,oh,0,0,3'd0,2'd2,op,0,0,0), {tag, "_rd2"});
            end
            4'd6: begin
                push(1'b0, ins, z, v(0,1,0,0,4'h0,0,0,3'd4,2'd1,op,0,0,0), {tag, "_dec"});
                push(1'b0, ins, z, v(0,1,0,1,4'h0,0,0,3'd0,2'd2,op,0,0,0), {tag, "_wr1"});
                push(1'b0, ins, z, v(0,0,0,0,4'h0,0,0,{1'b0,s},2'd0,op,1,0,0), {tag, "_wr2"});
            end
            4'd7, 4'd8: begin
                if (op == 4'd8 && !z) begin
                    push(1'b0, ins, z, v(0,0,0,1,4'h0,0,0,3'd0,2'd0,op,0,0,0), {tag, "_dec"});
                end else begin
                    push(1'b0, ins, z, v(0,1,0,0,4'h0,0,0,3'd4,2'd1,op,0,0,0), {tag, "_dec"});
                    push(1'b0, ins, z, v(0,1,0,0,4'h0,0,0,3'd0,2'd2,op,0,0,0), {tag, "_br1"});
                    push(1'b0, ins, z, v(0,0,1,0,4'h0,0,0,3'd0,2'd2,op,0,0,0), {tag, "_br2"});
                end
            end
            // NOP, HALT and illegal opcodes: S_DEC drives no strobes.
            default:
                push(1'b0, ins, z, v(0,0,0,0,4'h0,0,0,3'd0,2'd0,op,0,0,0), {tag, "_dec"});
        endcase
    endtask

    task automatic do_reset(input logic [7:0] ins, input logic z);
        @(negedge clk);
        rst = 1'b1; instruction = ins; zero = z;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; instruction = 8'h67; zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (obs !== 22'h0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 22'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0; #1;
        vectors++;
        if (obs !== v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'h6,0,0,0)) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs, v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'h6,0,0,0));
        end
        push_instr(8'h67, 1'b1, "first_wr");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_nop;
        do_reset(8'h00, 1'b0);
        push_instr(8'h00, 1'b0, "nop0");
        push_instr(8'h00, 1'b0, "nop1");
        push_instr(8'h00, 1'b0, "nop2");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_alu;
        do_reset(8'h16, 1'b0);
        push_instr(8'h16, 1'b0, "add_r1_r2");
        push_instr(8'h2B, 1'b0, "sub_r2_r3");
        push_instr(8'h31, 1'b1, "and_r0_r1");
        push_instr(8'h4D, 1'b0, "not_r3_r1");
        push_instr(8'h00, 1'b0, "alu_tail");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_mem;
        do_reset(8'h52, 1'b0);
        push_instr(8'h52, 1'b0, "rd_r2");
        push_instr(8'h67, 1'b0, "wr_r1");
        push_instr(8'h5C, 1'b0, "rd_r0");
        push_instr(8'h00, 1'b0, "mem_tail");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_branch;
        do_reset(8'h70, 1'b0);
        push_instr(8'h70, 1'b0, "br");
        push_instr(8'h80, 1'b0, "brz_not_taken");
        push_instr(8'h80, 1'b1, "brz_taken");
        push_instr(8'h00, 1'b0, "br_tail");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_halt;
        do_reset(8'hF0, 1'b0);
        push_instr(8'hF0, 1'b0, "halt");
        for (int i = 0; i < 20; i++)
            push(1'b0, 8'hF0, 1'b0, v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'hF,0,1,0), "halt_hold");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
        #2 rst = 1'b1;
        #1; vectors++;
        if (obs !== 22'h0) begin
            miscompares++;
            $display("FAIL halt_rst: got %h want %h", obs, 22'h0);
        end
        @(negedge clk);
        rst = 1'b0; #1;
        vectors++;
        if (obs !== v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'hF,0,0,0)) begin
            miscompares++;
            $display("FAIL halt_exit_idle: got %h want %h", obs, v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'hF,0,0,0));
        end
        push_instr(8'h00, 1'b0, "post_halt");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_illegal;
        do_reset(8'hA0, 1'b0);
        push_instr(8'hA0, 1'b0, "illegal");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++)
            push(1'b0, 8'hA0, 1'b0, v(0,0,0,0,4'h0,0,0,3'd0,2'd0,4'hA,0,1,1), "illegal_trap");
`else
        push_instr(8'hE3, 1'b1, "illegal_e3");
        push_instr(8'h00, 1'b0, "illegal_tail");
`endif
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
        @(negedge clk);
        rst = 1'b1; #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_err_cleared: got %b want %b", err, 1'b0);
        end
    endtask

    task automatic test_reset_mid_write;
        do_reset(8'h67, 1'b0);
        push_instr(8'h67, 1'b0, "wr_before_rst");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
        // Still inside S_WR2: raise reset mid-cycle.
        #2 rst = 1'b1;
        #1; vectors++;
        if (obs !== 22'h0) begin
            miscompares++;
            $display("FAIL wr2_rst_drop: got %h want %h", obs, 22'h0);
        end
        @(posedge clk); #1;
        vectors++;
        if (write !== 1'b0) begin
            miscompares++;
            $display("FAIL wr2_rst_no_write: got %b want %b", write, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        push_instr(8'h00, 1'b0, "post_wr_rst");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] prog [10];
        logic       zs   [10];
        prog = '{8'h16, 8'h52, 8'h4D, 8'h80, 8'h67, 8'h80, 8'h2B, 8'h00, 8'h70, 8'h00};
        zs   = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        do_reset(prog[0], zs[0]);
        for (int i = 0; i < 10; i++)
            push_instr(prog[i], zs[i], $sformatf("b2b%0d_%h", i, prog[i]));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            if (it.drive) begin instruction = it.ins; zero = it.z; end
            #1; vectors++;
            if (obs !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_nop;
        test_alu;
        test_mem;
        test_branch;
        test_halt;
        test_illegal;
        test_reset_mid_write;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
